// File: rtl/magnitude_search.sv
`default_nettype none
// ============================================================================
// Module   : magnitude_search
// Brief    : Binary-search controller that drives the probe operand of an
//            external magnitude comparator to recover an unknown target value.
// Revision : 1.0 - initial release
// ============================================================================
module magnitude_search #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             a_less_b,
    input  logic             a_equal_b,
    input  logic             a_greater_b,
    output logic [WIDTH-1:0] probe,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic             err,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_SEARCH = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] C_MAX = {WIDTH{1'b1}};

    // floor((a+b)/2) without a carry out of WIDTH bits
    function automatic logic [WIDTH-1:0] f_mid(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        return (a >> 1) + (b >> 1) + WIDTH'(a[0] & b[0]);
    endfunction

    state_t           r_state, w_state;
    logic [WIDTH-1:0] r_lo, w_lo;
    logic [WIDTH-1:0] r_hi, w_hi;
    logic [WIDTH-1:0] r_probe, w_probe;
    logic             r_busy, w_busy;
    logic             r_done, w_done;
    logic             r_found, w_found;
    logic             r_err, w_err;
    logic [WIDTH-1:0] r_result, w_result;
    logic             w_finish;
    logic             w_onehot;
    logic [WIDTH-1:0] w_inc;
    logic [WIDTH-1:0] w_dec;

    assign w_onehot = $onehot({a_less_b, a_equal_b, a_greater_b});
    // Only consumed when the probe is known not to sit on the matching bound
    assign w_inc    = r_probe + WIDTH'(1);
    assign w_dec    = r_probe - WIDTH'(1);

    always_comb begin
        w_state  = r_state;
        w_lo     = r_lo;
        w_hi     = r_hi;
        w_probe  = r_probe;
        w_busy   = r_busy;
        w_done   = 1'b0;
        w_found  = r_found;
        w_err    = r_err;
        w_result = r_result;
        w_finish = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_lo    = '0;
                    w_hi    = C_MAX;
                    w_probe = C_MAX >> 1;
                    w_busy  = 1'b1;
                    w_state = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                w_finish = 1'b1;
                w_found  = 1'b0;
                w_err    = 1'b0;
                w_result = '0;
                if (!w_onehot) begin
                    w_err = 1'b1;
                end else if (a_equal_b) begin
                    w_found  = 1'b1;
                    w_result = r_probe;
                end else if (a_greater_b) begin
                    if (r_probe != C_MAX && w_inc <= r_hi) begin
                        w_finish = 1'b0;
                        w_lo     = w_inc;
                        w_probe  = f_mid(w_inc, r_hi);
                    end
                end else begin
                    if (r_probe != '0 && r_lo <= w_dec) begin
                        w_finish = 1'b0;
                        w_hi     = w_dec;
                        w_probe  = f_mid(r_lo, w_dec);
                    end
                end
                // Result registers only change when a search actually ends
                if (w_finish) begin
                    w_done  = 1'b1;
                    w_busy  = 1'b0;
                    w_state = ST_IDLE;
                end else begin
                    w_found  = r_found;
                    w_err    = r_err;
                    w_result = r_result;
                end
            end
            default: begin
                w_state = ST_IDLE;
                w_busy  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_lo     <= '0;
            r_hi     <= C_MAX;
            r_probe  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_found  <= 1'b0;
            r_err    <= 1'b0;
            r_result <= '0;
        end else begin
            r_state  <= w_state;
            r_lo     <= w_lo;
            r_hi     <= w_hi;
            r_probe  <= w_probe;
            r_busy   <= w_busy;
            r_done   <= w_done;
            r_found  <= w_found;
            r_err    <= w_err;
            r_result <= w_result;
        end
    end

    assign probe  = r_probe;
    assign busy   = r_busy;
    assign done   = r_done;
    assign found  = r_found;
    assign err    = r_err;
    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_magnitude_search.sv
`default_nettype none
// ============================================================================
// Module   : tb_magnitude_search
// Brief    : Directed bench for magnitude_search at WIDTH=2 and WIDTH=4 with
//            behavioural comparator models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_magnitude_search;

    logic       clk;
    logic       rst;

    // WIDTH=2 instance
    logic       start2;
    logic       lt2, eq2, gt2;
    logic [1:0] probe2, result2;
    logic       busy2, done2, found2, err2;
    int         target2;
    int         mode2;          // 0 model, 1 forced flags, 2 always greater, 3 always less
    logic [2:0] force2;         // {less, equal, greater}

    // WIDTH=4 instance
    logic       start4;
    logic       lt4, eq4, gt4;
    logic [3:0] probe4, result4;
    logic       busy4, done4, found4, err4;
    int         target4;

    int tests_run;
    int tests_failed;
    int probes[0:15];
    int k;

    magnitude_search #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2),
        .a_less_b(lt2), .a_equal_b(eq2), .a_greater_b(gt2),
        .probe(probe2), .busy(busy2), .done(done2),
        .found(found2), .err(err2), .result(result2)
    );

    magnitude_search #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4),
        .a_less_b(lt4), .a_equal_b(eq4), .a_greater_b(gt4),
        .probe(probe4), .busy(busy4), .done(done4),
        .found(found4), .err(err4), .result(result4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        {lt2, eq2, gt2} = 3'b000;
        case (mode2)
            0: {lt2, eq2, gt2} = {target2 < int'(probe2), target2 == int'(probe2),
                                  target2 > int'(probe2)};
            1: {lt2, eq2, gt2} = force2;
            2: {lt2, eq2, gt2} = 3'b001;
            3: {lt2, eq2, gt2} = 3'b100;
            default: {lt2, eq2, gt2} = 3'b000;
        endcase
    end

    always_comb begin
        lt4 = target4 < int'(probe4);
        eq4 = target4 == int'(probe4);
        gt4 = target4 > int'(probe4);
    end

    task automatic check(input string tag, input int got, input int exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One WIDTH=2 search; probes[] holds the probe seen at each compare.
    // extra_start re-asserts start for one cycle during the search.
    task automatic run2(input bit extra_start);
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        k = 0;
        probes[0] = int'(probe2);
        check("busy_after_start", int'(busy2), 1);
        while (1) begin
            if (extra_start && k == 0) start2 = 1'b1;
            @(posedge clk);
            #1;
            start2 = 1'b0;
            k++;
            if (done2) break;
            if (k >= 8) begin
                check("search_timeout", 0, 1);
                break;
            end
            probes[k] = int'(probe2);
        end
        check("busy_at_done", int'(busy2), 0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst     = 1'b1;
        start2  = 1'b0;
        start4  = 1'b0;
        target2 = 0;
        target4 = 0;
        mode2   = 0;
        force2  = 3'b000;

        repeat (2) @(posedge clk);
        #1;
        check("rst_probe", int'(probe2), 0);
        check("rst_busy", int'(busy2), 0);
        check("rst_done", int'(done2), 0);
        check("rst_found", int'(found2), 0);
        check("rst_err", int'(err2), 0);
        check("rst_result", int'(result2), 0);
        @(negedge clk);
        rst = 1'b0;

        // Shortest search
        target2 = 1;
        run2(1'b0);
        check("t1_k", k, 1);
        check("t1_probe0", probes[0], 1);
        check("t1_found", int'(found2), 1);
        check("t1_result", int'(result2), 1);
        check("t1_err", int'(err2), 0);
        @(posedge clk);
        #1;
        check("t1_done_fall", int'(done2), 0);
        check("t1_result_hold", int'(result2), 1);

        // Longest search, both ends
        target2 = 3;
        run2(1'b0);
        check("t2_k", k, 3);
        check("t2_p0", probes[0], 1);
        check("t2_p1", probes[1], 2);
        check("t2_p2", probes[2], 3);
        check("t2_found", int'(found2), 1);
        check("t2_result", int'(result2), 3);
        target2 = 0;
        run2(1'b0);
        check("t2b_k", k, 2);
        check("t2b_p1", probes[1], 0);
        check("t2b_found", int'(found2), 1);
        check("t2b_result", int'(result2), 0);

        // Protocol errors
        mode2  = 1;
        force2 = 3'b000;
        run2(1'b0);
        check("t4a_k", k, 1);
        check("t4a_err", int'(err2), 1);
        check("t4a_found", int'(found2), 0);
        check("t4a_result", int'(result2), 0);
        target2 = 3;
        mode2   = 0;
        run2(1'b0);
        check("t4_recover_result", int'(result2), 3);
        mode2  = 1;
        force2 = 3'b110;
        run2(1'b0);
        check("t4b_err", int'(err2), 1);
        check("t4b_found", int'(found2), 0);
        check("t4b_result", int'(result2), 0);

        // Bound exhaustion
        mode2 = 2;
        run2(1'b0);
        check("t5a_k", k, 3);
        check("t5a_p0", probes[0], 1);
        check("t5a_p1", probes[1], 2);
        check("t5a_p2", probes[2], 3);
        check("t5a_found", int'(found2), 0);
        check("t5a_err", int'(err2), 0);
        mode2 = 3;
        run2(1'b0);
        check("t5b_k", k, 2);
        check("t5b_p1", probes[1], 0);
        check("t5b_found", int'(found2), 0);
        check("t5b_err", int'(err2), 0);
        check("t5b_probe_nowrap", int'(probe2), 0);

        // Start during search is ignored and not queued
        mode2   = 0;
        target2 = 3;
        run2(1'b1);
        check("t6_k", k, 3);
        check("t6_p1", probes[1], 2);
        check("t6_p2", probes[2], 3);
        check("t6_result", int'(result2), 3);
        repeat (2) @(posedge clk);
        #1;
        check("t6_not_queued", int'(busy2), 0);

        // Asynchronous reset mid-search
        @(negedge clk);
        target2 = 2;
        start2  = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("t6_rst_busy", int'(busy2), 0);
        check("t6_rst_probe", int'(probe2), 0);
        check("t6_rst_found", int'(found2), 0);
        check("t6_rst_result", int'(result2), 0);
        check("t6_rst_done", int'(done2), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("t6_no_done_after_rst", int'(done2), 0);
        end
        run2(1'b0);
        check("t6_fresh_k", k, 2);
        check("t6_fresh_found", int'(found2), 1);
        check("t6_fresh_result", int'(result2), 2);

        // Exhaustive sweep at WIDTH=4
        for (int t = 0; t < 16; t++) begin
            int kk;
            bit busy_ok;
            target4 = t;
            busy_ok = 1'b1;
            @(negedge clk);
            start4 = 1'b1;
            @(posedge clk);
            #1;
            start4 = 1'b0;
            if (!busy4) busy_ok = 1'b0;
            kk = 0;
            while (1) begin
                @(posedge clk);
                #1;
                kk++;
                if (done4) break;
                if (!busy4) busy_ok = 1'b0;
                if (kk >= 10) break;
            end
            if (busy4) busy_ok = 1'b0;
            check("t3_done_within_5", int'(done4 && kk <= 5), 1);
            check("t3_found", int'(found4), 1);
            check("t3_result", int'(result4), t);
            check("t3_busy_window", int'(busy_ok), 1);
            @(posedge clk);
            #1;
            check("t3_busy_after", int'(busy4), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/magnitude_search.md
# magnitude_search

Binary-search controller that drives the probe operand of an external magnitude comparator and consumes its less, equal and greater outputs to recover an unknown WIDTH-bit target value. The comparator is combinational and compares the target (operand A) against this block's probe (operand B). The block sits between the comparator and any consumer that needs the target value as a binary number. Each search takes at most WIDTH+1 compare cycles.

## Interface
- WIDTH, default 2: operand width in bits; WIDTH ≥ 1.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a search; sampled only while busy=0.
- a_less_b  input  1  comparator output: target < probe.
- a_equal_b  input  1  comparator output: target == probe.
- a_greater_b  input  1  comparator output: target > probe.
- probe  output  WIDTH  registered operand B driven to the comparator.
- busy  output  1  high while a search is in progress.
- done  output  1  one-cycle pulse when a search ends.
- found  output  1  valid with done; high if the target was located.
- err  output  1  valid with done; high if the comparator flags were not one-hot.
- result  output  WIDTH  valid with done; located value, 0 when found=0.

## Operation
- States: IDLE and SEARCH. All outputs are registered.
- Bounds lo and hi are WIDTH bits wide. MAX = 2^WIDTH − 1. mid = (lo + hi) >> 1, computed at WIDTH+1 bits so the sum cannot wrap.
- IDLE with start=1:
  - lo←0, hi←MAX, probe←MAX>>1.
  - busy←1, go to SEARCH.
- IDLE with start=0: hold.
- SEARCH, evaluated each cycle on the flags for the current probe:
  - Flags not exactly one-hot (000, 011, 111, …): err←1, found←0, result←0, done←1, busy←0, go to IDLE.
  - a_equal_b: found←1, err←0, result←probe, done←1, busy←0, go to IDLE.
  - a_greater_b with probe==MAX, or a_less_b with probe==0: bound exhausted. found←0, err←0, result←0, done←1, busy←0, go to IDLE. Underflow and overflow never wrap.
  - a_greater_b otherwise: lo←probe+1, probe←mid(probe+1, hi). If probe+1 > hi: not-found exit as above.
  - a_less_b otherwise: hi←probe−1, probe←mid(lo, probe−1). If lo > probe−1: not-found exit as above.
- Start while busy=1 is ignored. It is not queued.
- done is high for exactly one cycle and deasserts on the next clock. found, err and result hold their values until the next search ends.
- probe holds its last value in IDLE.
- A target that changes mid-search is not supported. The search still terminates within WIDTH+1 compares, via the not-found exit.

## Timing
- Reset (asynchronous, takes effect immediately, mid-search included): state=IDLE, probe=0, busy=0, done=0, found=0, err=0, result=0, lo=0, hi=MAX. Any in-progress search is abandoned and no done pulse is produced.
- Edge t: start sampled in IDLE. probe and busy update at edge t.
- Compare k (k = 1…K) samples the flags at edge t+k. probe changes at most once per cycle, so the comparator has one full cycle to settle.
- done, found, err and result rise at edge t+K and busy falls at edge t+K. done falls at edge t+K+1.
- K ≤ WIDTH+1. Earliest restart: a start sampled at edge t+K+1.
- Back-to-back searches: with start held high, a new search begins at edge t+K+1.

## Test plan
Unless stated otherwise, WIDTH=2 and the comparator is a behavioural model with target T.

1. Shortest search:
   - Stimulus: T=1, start pulse.
   - Required: probe=1; done at the first compare edge; found=1, result=1, err=0, K=1.
2. Longest search:
   - Stimulus: T=3.
   - Required: probe sequence 1, 2, 3; K=3; found=1, result=3. Repeat with T=0: probes 1, 0; K=2; result=0.
3. Exhaustive sweep at WIDTH=4:
   - Stimulus: T=0…15.
   - Required: result=T and found=1 every time; K ≤ 5; busy high from the start edge to the done edge only.
4. Protocol error:
   - Stimulus: force flags to 000 at the first compare, then to 110 in a second search.
   - Required: done with err=1, found=0, result=0 in both searches.
5. Bound exhaustion:
   - Stimulus: the model always answers greater.
   - Required: probes 1, 2, 3; done with found=0, err=0. Repeat answering always less: probes 1, 0, then found=0. No wrap in either case.
6. Control edge cases:
   - Stimulus: assert start during SEARCH, then assert rst mid-search.
   - Required: extra start has no effect on the probe sequence. rst returns all outputs to 0 immediately, with no done pulse. A fresh start after reset completes normally.
